// File: rtl/snn_ss_pkg.sv
// Shared definitions for the signed stochastic-stream readout.
// Holds the conversion FSM state encoding and the derived-width helpers so
// the interface, the top and the bench all agree on counter/output widths.
package snn_ss_pkg;

  // 2'd3 is unused; the FSM treats it as illegal and falls back to IDLE.
  typedef enum logic [1:0] {
    SS_CONV_IDLE = 2'd0,
    SS_CONV_RUN  = 2'd1,
    SS_CONV_DONE = 2'd2
  } ss_conv_state_t;

  // Event counters must hold the full window count W = 2^nb_win.
  function automatic int nb_cnt(input int nb_win);
    return nb_win + 1;
  endfunction

  // Signed result spans -W..+W, one bit wider than a counter.
  function automatic int nb_out(input int nb_win);
    return nb_win + 2;
  endfunction

endpackage

// File: rtl/ss_signed_stream_to_binary_if.sv
// Stream/result bundle between a signed stochastic source and the readout.
// Ports: START/IN/SIGN flow from the source (master) into the converter (slave);
// BUSY/VALID/VALUE/POS_CNT/NEG_CNT flow back from the converter.
interface ss_signed_stream_to_binary_if
  import snn_ss_pkg::*;
#(
  parameter int NB_WIN = 8
);

  localparam int NB_CNT = nb_cnt(NB_WIN);
  localparam int NB_OUT = nb_out(NB_WIN);

  logic                     START;
  logic                     IN;
  logic                     SIGN;
  logic                     BUSY;
  logic                     VALID;
  logic signed [NB_OUT-1:0] VALUE;
  logic [NB_CNT-1:0]        POS_CNT;
  logic [NB_CNT-1:0]        NEG_CNT;

  modport master (
    output START, IN, SIGN,
    input  BUSY, VALID, VALUE, POS_CNT, NEG_CNT
  );

  modport slave (
    input  START, IN, SIGN,
    output BUSY, VALID, VALUE, POS_CNT, NEG_CNT
  );

endinterface

// File: rtl/ss_event_counter.sv
// Event up-counter with synchronous clear (clear wins over enable).
// Latency: count visible one cycle after the enabling edge.
// Backpressure: none; counts every enabled cycle.
// Ports: CLK clock, clr synchronous clear, en count enable, cnt current count.
module ss_event_counter #(
  parameter int NB_CNT = 9
) (
  input  logic              CLK,
  input  logic              clr,
  input  logic              en,
  output logic [NB_CNT-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + NB_CNT'(1);
    end
  end

endmodule

// File: rtl/ss_signed_stream_to_binary.sv
// Integrates a sign-magnitude stochastic bitstream over 2^NB_WIN cycles into pos-neg.
// Latency: START accepted at edge t, samples at t+1..t+W, VALID high the cycle after t+W.
// Backpressure: none; START is ignored while BUSY, and START during DONE chains a new window.
// Ports: CLK clock, INIT sync active-high reset, bus (slave) carries START/IN/SIGN in and
// BUSY/VALID/VALUE/POS_CNT/NEG_CNT out.
module ss_signed_stream_to_binary
  import snn_ss_pkg::*;
#(
  parameter int NB_WIN = 8
) (
  input logic                          CLK,
  input logic                          INIT,
  ss_signed_stream_to_binary_if.slave  bus
);

  localparam int NB_CNT = nb_cnt(NB_WIN);
  localparam int NB_OUT = nb_out(NB_WIN);
  localparam logic [NB_WIN-1:0] LAST_CYC = '1;

  ss_conv_state_t           state;
  logic [NB_WIN-1:0]        cyc_cnt;
  logic [NB_CNT-1:0]        pos_cnt;
  logic [NB_CNT-1:0]        neg_cnt;
  logic [NB_CNT-1:0]        pos_nxt;
  logic [NB_CNT-1:0]        neg_nxt;
  logic signed [NB_OUT-1:0] value_nxt;
  logic signed [NB_OUT-1:0] value_q;
  logic [NB_CNT-1:0]        pos_q;
  logic [NB_CNT-1:0]        neg_q;
  logic                     busy_q;
  logic                     valid_q;
  logic                     run;
  logic                     start_ok;
  logic                     cnt_clr;
  logic                     pos_evt;
  logic                     neg_evt;

  assign run      = (state == SS_CONV_RUN);
  assign start_ok = bus.START && ((state == SS_CONV_IDLE) || (state == SS_CONV_DONE));
  assign cnt_clr  = INIT || start_ok;
  assign pos_evt  = run && bus.IN && !bus.SIGN;
  assign neg_evt  = run && bus.IN && bus.SIGN;

  ss_event_counter #(.NB_CNT(NB_CNT)) u_pos_cnt (
    .CLK (CLK),
    .clr (cnt_clr),
    .en  (pos_evt),
    .cnt (pos_cnt)
  );

  ss_event_counter #(.NB_CNT(NB_CNT)) u_neg_cnt (
    .CLK (CLK),
    .clr (cnt_clr),
    .en  (neg_evt),
    .cnt (neg_cnt)
  );

  // The last sample lands on the same edge the results are captured, so the
  // captured totals must include this cycle's event on top of the counter value.
  assign pos_nxt   = pos_cnt + NB_CNT'(pos_evt);
  assign neg_nxt   = neg_cnt + NB_CNT'(neg_evt);
  assign value_nxt = $signed({1'b0, pos_nxt}) - $signed({1'b0, neg_nxt});

  always_ff @(posedge CLK) begin
    if (INIT) begin
      state   <= SS_CONV_IDLE;
      cyc_cnt <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      value_q <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        SS_CONV_IDLE: begin
          busy_q <= 1'b0;
          if (bus.START) begin
            state   <= SS_CONV_RUN;
            cyc_cnt <= '0;
            busy_q  <= 1'b1;
          end
        end
        SS_CONV_RUN: begin
          cyc_cnt <= cyc_cnt + NB_WIN'(1);
          if (cyc_cnt == LAST_CYC) begin
            state   <= SS_CONV_DONE;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            value_q <= value_nxt;
            pos_q   <= pos_nxt;
            neg_q   <= neg_nxt;
          end
        end
        SS_CONV_DONE: begin
          if (bus.START) begin
            state   <= SS_CONV_RUN;
            cyc_cnt <= '0;
            busy_q  <= 1'b1;
          end else begin
            state  <= SS_CONV_IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= SS_CONV_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.BUSY    = busy_q;
  assign bus.VALID   = valid_q;
  assign bus.VALUE   = value_q;
  assign bus.POS_CNT = pos_q;
  assign bus.NEG_CNT = neg_q;

endmodule

// File: tb/tb_ss_signed_stream_to_binary.sv
module tb_ss_signed_stream_to_binary;

  localparam int NB_WIN = 4;
  localparam int W      = 1 << NB_WIN;

  logic CLK;
  logic INIT;
  int   cyc;
  int   total;
  int   bad;
  bit   s_in   [W];
  bit   s_sign [W];
  int   last_value;
  int   v_cyc;
  int   v_cyc_first;

  ss_signed_stream_to_binary_if #(.NB_WIN(NB_WIN)) bus ();

  ss_signed_stream_to_binary #(.NB_WIN(NB_WIN)) dut (
    .CLK  (CLK),
    .INIT (INIT),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // 0 all positive, 1 all negative, 2 shuffled 10 pos/4 neg/2 idle,
  // 3 random, 4 IN=0 with SIGN toggling.
  task automatic fill(input int mode);
    for (int k = 0; k < W; k++) begin
      case (mode)
        0: begin s_in[k] = 1'b1; s_sign[k] = 1'b0; end
        1: begin s_in[k] = 1'b1; s_sign[k] = 1'b1; end
        2: begin
          if (k < 10)      begin s_in[k] = 1'b1; s_sign[k] = 1'b0; end
          else if (k < 14) begin s_in[k] = 1'b1; s_sign[k] = 1'b1; end
          else             begin s_in[k] = 1'b0; s_sign[k] = 1'($urandom % 2); end
        end
        3: begin s_in[k] = 1'($urandom % 2); s_sign[k] = 1'($urandom % 2); end
        default: begin s_in[k] = 1'b0; s_sign[k] = 1'(k % 2); end
      endcase
    end
    if (mode == 2) begin
      for (int k = W - 1; k > 0; k--) begin
        int j;
        bit ti, ts;
        j = $urandom_range(k, 0);
        ti = s_in[k];   s_in[k]   = s_in[j];   s_in[j]   = ti;
        ts = s_sign[k]; s_sign[k] = s_sign[j]; s_sign[j] = ts;
      end
    end
  endtask

  // Starts a window (from IDLE or DONE), feeds the W samples and checks the result.
  task automatic run_window(input string tag, input bit hold_start, input bit chain);
    int p;
    int n;
    p = 0;
    n = 0;
    for (int k = 0; k < W; k++) begin
      if (s_in[k] && !s_sign[k]) p++;
      if (s_in[k] && s_sign[k])  n++;
    end
    bus.START = 1'b1;
    bus.IN    = 1'b1;
    bus.SIGN  = 1'b0;
    step();
    chk({tag, "_busy_run"}, bus.BUSY, 1);
    for (int k = 0; k < W; k++) begin
      bus.START = hold_start;
      bus.IN    = s_in[k];
      bus.SIGN  = s_sign[k];
      step();
      if (k < W - 1) chk({tag, "_early_valid"}, bus.VALID, 0);
    end
    v_cyc = cyc;
    chk({tag, "_valid"}, bus.VALID, 1);
    chk({tag, "_busy_done"}, bus.BUSY, 0);
    chk({tag, "_value"}, bus.VALUE, p - n);
    chk({tag, "_pos"}, bus.POS_CNT, p);
    chk({tag, "_neg"}, bus.NEG_CNT, n);
    last_value = p - n;
    bus.START = chain;
    bus.IN    = 1'b0;
  endtask

  task automatic after_done(input string tag);
    bus.START = 1'b0;
    step();
    chk({tag, "_valid_drop"}, bus.VALID, 0);
    chk({tag, "_idle_busy"}, bus.BUSY, 0);
    chk({tag, "_hold"}, bus.VALUE, last_value);
  endtask

  initial begin
    int seen;
    total = 0;
    bad   = 0;
    last_value = 0;

    // Reset with START and IN asserted: INIT must win.
    INIT = 1'b1;
    bus.START = 1'b1;
    bus.IN    = 1'b1;
    bus.SIGN  = 1'b0;
    step();
    step();
    chk("rst_busy",  bus.BUSY, 0);
    chk("rst_valid", bus.VALID, 0);
    chk("rst_value", bus.VALUE, 0);
    chk("rst_pos",   bus.POS_CNT, 0);
    chk("rst_neg",   bus.NEG_CNT, 0);
    INIT = 1'b0;
    bus.START = 1'b0;
    step();
    chk("idle_busy", bus.BUSY, 0);

    fill(0);
    run_window("allpos", 1'b0, 1'b0);
    chk("allpos_posmsb", bus.POS_CNT[NB_WIN], 1);
    after_done("allpos");

    // Abort mid-window: no VALID, outputs back to zero.
    fill(3);
    bus.START = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      bus.START = 1'b0;
      bus.IN    = 1'b1;
      bus.SIGN  = s_sign[k];
      step();
    end
    INIT = 1'b1;
    step();
    INIT = 1'b0;
    chk("abort_busy",  bus.BUSY, 0);
    chk("abort_valid", bus.VALID, 0);
    chk("abort_value", bus.VALUE, 0);
    chk("abort_pos",   bus.POS_CNT, 0);
    chk("abort_neg",   bus.NEG_CNT, 0);
    seen = 0;
    for (int k = 0; k < W + 4; k++) begin
      bus.IN   = 1'($urandom % 2);
      bus.SIGN = 1'($urandom % 2);
      step();
      if (bus.VALID !== 1'b0 || bus.BUSY !== 1'b0) seen++;
    end
    chk("abort_quiet", seen, 0);
    last_value = 0;

    fill(1);
    run_window("allneg", 1'b0, 1'b0);
    chk("allneg_bits", {26'd0, bus.VALUE}, 32'sb110000);
    after_done("allneg");

    fill(2);
    run_window("mixed", 1'b0, 1'b0);
    after_done("mixed");

    // START held through RUN must not restart the window.
    fill(3);
    run_window("hold", 1'b1, 1'b0);
    after_done("hold");

    // Back-to-back windows: second VALID exactly W+1 cycles after the first.
    fill(3);
    run_window("chain1", 1'b0, 1'b1);
    v_cyc_first = v_cyc;
    fill(3);
    run_window("chain2", 1'b0, 1'b0);
    chk("chain_gap", v_cyc - v_cyc_first, W + 1);
    after_done("chain2");

    for (int r = 0; r < 3; r++) begin
      fill(3);
      run_window("rand", 1'b0, 1'b0);
      after_done("rand");
    end

    fill(0);
    run_window("pre_zero", 1'b0, 1'b0);
    after_done("pre_zero");
    fill(4);
    run_window("zero", 1'b0, 1'b0);
    after_done("zero");
    step();
    chk("zero_hold2", bus.VALUE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
